// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages and pipe_hazard_ctrl.
//   master : stage side. It drives rdy, stall_req and flush_req, and receives
//            stall_cmd, flush_cmd, busy and stall_cycles.
//   slave  : controller side. The directions are mirrored.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              rdy;
  logic [STAGES-1:0] stall_req;
  logic [STAGES-1:0] flush_req;
  logic [STAGES-1:0] stall_cmd;
  logic [STAGES-1:0] flush_cmd;
  logic              busy;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rdy, stall_req, flush_req,
    input  stall_cmd, flush_cmd, busy, stall_cycles
  );

  modport slave (
    input  rdy, stall_req, flush_req,
    output stall_cmd, flush_cmd, busy, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller.
// The stall vector is combinational. The highest stalling stage holds, and so
// does every stage before it. A flush is sequenced as Run -> Flush -> Hold:
//   - Flush lasts one cycle and pulses flush_cmd for the stages behind the source.
//   - Hold keeps IF stalled for HOLD_CYCLES cycles while the redirect lands.
// Ports:
//   clk, rst : core clock and synchronous active-high reset
//   bus      : slave side of pipe_hazard_ctrl_if. It carries rdy, stall_req and
//              flush_req in, and stall_cmd, flush_cmd, busy and stall_cycles out.
// Build option: define CTRL_PERF_EN to implement the stall_cycles counter.
// Otherwise stall_cycles is tied to zero.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES      = 5,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {StRun, StFlush, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   src_q, src_d;
  logic [STAGES-1:0] mask_q, mask_d;

  logic [IdxW-1:0]   s_idx, f_idx;
  logic [STAGES-1:0] f_mask, base_stall, stall_cmd, flush_cmd;
  logic              stall_any, flush_any, accept, preempt;

  // Sets bit k when any bit at index >= k is set, giving bits [highest:0].
  function automatic logic [STAGES-1:0] fill_down(input logic [STAGES-1:0] v);
    logic              acc;
    logic [STAGES-1:0] r;
    acc = 1'b0;
    r   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc  = acc | v[k];
      r[k] = acc;
    end
    return r;
  endfunction

  always_comb begin
    s_idx  = '0;
    f_idx  = '0;
    f_mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (bus.stall_req[k]) s_idx = IdxW'(k);
      if (bus.flush_req[k]) f_idx = IdxW'(k);
    end
    for (int k = 0; k < STAGES; k++) begin
      f_mask[k] = (k < int'(f_idx));
    end
  end

  assign stall_any  = |bus.stall_req;
  assign flush_any  = |bus.flush_req;
  assign base_stall = fill_down(bus.stall_req);
  // A flush whose source stage is itself behind a stall must wait.
  assign accept     = flush_any && (!stall_any || (s_idx <= f_idx));
  assign preempt    = accept && (f_idx > src_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    mask_d    = mask_q;
    stall_cmd = '0;
    flush_cmd = '0;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          // Stages about to be flushed must not hold the pipe.
          stall_cmd = fill_down(bus.stall_req & ~f_mask);
          src_d     = f_idx;
          mask_d    = f_mask;
          state_d   = StFlush;
        end else begin
          stall_cmd = base_stall;
        end
      end
      StFlush: begin
        flush_cmd = mask_q;
        stall_cmd = base_stall & ~mask_q;
        if (preempt) begin
          src_d   = f_idx;
          mask_d  = f_mask;
          state_d = StFlush;
        end else if (HOLD_CYCLES > 0) begin
          cnt_d   = 4'(HOLD_CYCLES);
          state_d = StHold;
        end else begin
          state_d = StRun;
        end
      end
      StHold: begin
        stall_cmd = base_stall | STAGES'(1);
        if (preempt) begin
          src_d   = f_idx;
          mask_d  = f_mask;
          state_d = StFlush;
        end else if (cnt_q <= 4'd1) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StRun;
    endcase
    // A global not-ready freezes everything and holds the whole pipe.
    if (!bus.rdy) begin
      stall_cmd = '1;
      flush_cmd = '0;
      state_d   = state_q;
      cnt_d     = cnt_q;
      src_d     = src_q;
      mask_d    = mask_q;
    end
    if (rst) stall_cmd = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      src_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.stall_cmd = stall_cmd;
  assign bus.flush_cmd = flush_cmd;
  assign bus.busy      = (state_q != StRun);

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (bus.rdy && (|stall_cmd) && !(&stall_cycles_q)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the RISC-V core.
- Collects per-stage stall and flush requests.
- Drives a per-stage stall vector (highest requesting stage wins; it and all earlier stages hold).
- Sequences flushes through a small FSM: a one-cycle registered flush pulse to the stages behind the requester, then a configurable IF hold while the fetch redirect lands.
- Sits beside the stage modules; outputs fan out to every pipeline register.

Parameters:
STAGES, 5, number of pipeline stages; bit 0 = IF, bit STAGES-1 = last stage
HOLD_CYCLES, 1, IF-hold cycles after each flush pulse; 0..15
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global ready; low freezes the controller
stall_req  in  STAGES  per-stage stall request, level
flush_req  in  STAGES  per-stage flush request (branch/exception source), level, held until accepted
stall_cmd  out  STAGES  stall vector; bit k holds stage k
flush_cmd  out  STAGES  registered flush pulse; bit k clears stage k's output register
busy  out  1  high whenever state is not S_RUN
stall_cycles  out  CNT_W  count of cycles with any stall_cmd bit set

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state S_RUN, flush_cmd 0, busy 0, hold counter 0, latched source 0, stall_cycles 0. While rst=1, stall_cmd=0.
- Index rules:
  - s = highest index with stall_req set.
  - f = highest index with flush_req set.
  - base_stall = bits [s:0] set; all zero if no stall_req.
- stall_cmd is combinational, zero latency from stall_req.
- rdy=0 (not in reset):
  - stall_cmd = all ones, flush_cmd = 0.
  - state, hold counter, latched source and stall_cycles all frozen.
  - On rdy return, the FSM resumes exactly where it froze.
- S_RUN:
  - No flush_req: stall_cmd = base_stall.
  - flush_req present and s > f: flush not accepted (the flushing stage is itself stalled). stall_cmd = base_stall; requester keeps flush_req high.
  - flush_req present and (no stall or s <= f): accept.
    - This cycle, stall_cmd = base_stall computed only from stall_req bits at index >= f; requests from stages being flushed are ignored.
    - Latch src=f and mask = bits [f-1:0]. For f=0, mask=0 and the flush is a no-op pulse.
    - Next state S_FLUSH.
- S_FLUSH (exactly one cycle):
  - flush_cmd = mask; stall_cmd = base_stall masked to bits >= src.
  - Next state: S_HOLD with counter = HOLD_CYCLES if HOLD_CYCLES > 0, else S_RUN.
  - flush_cmd is 0 in every other state.
- S_HOLD:
  - stall_cmd = base_stall | bit 0.
  - Counter decrements each rdy cycle; at 1 -> S_RUN.
- Preemption:
  - In S_FLUSH or S_HOLD, a flush_req with f > src (and s <= f) is accepted: relatch src/mask, go S_FLUSH next cycle, hold counter restarts.
  - flush_req with f <= src is ignored until S_RUN.
- Simultaneous flush_req and stall_req from the same stage: the flush is accepted (s <= f) and that stage stalls that cycle.
- busy = (state != S_RUN), registered with the state.
- stall_cycles:
  - Increments by 1 on each rdy=1 cycle with stall_cmd != 0.
  - Saturates at all ones; no wrap.
  - rdy=0 freeze cycles are not counted.

Optional Feature:
Macro CTRL_PERF_EN.
- Defined: stall_cycles counter implemented as above.
- Undefined: counter logic removed; stall_cycles tied to 0.
- All other behaviour identical either way.

Test Plan:
- STAGES=5, HOLD_CYCLES=1, rdy=1: stall_req=01000 -> stall_cmd=01111 same cycle; stall_req=00001 -> 00001; stall_req=01001 -> 01111; stall_req=0 -> 00000.
- flush_req=00100 for one cycle (accepted at cycle T) -> T: stall_cmd=0, busy=0; T+1: flush_cmd=00011, busy=1; T+2: flush_cmd=0, stall_cmd=00001; T+3: stall_cmd=0, busy=0.
- flush_req=00100 held with stall_req=01000 for 3 cycles -> no flush_cmd, stall_cmd=01111; stall drops at cycle 3 -> flush accepted, flush_cmd=00011 one cycle later.
- Preemption: flush from bit 2 accepted, then during S_HOLD flush_req=01000 -> next cycle flush_cmd=00111, hold restarts. A bit-1 flush during S_HOLD -> ignored.
- rdy=0 for 4 cycles during S_HOLD -> stall_cmd=11111, flush_cmd=0, counter/state frozen; rdy=1 -> remaining hold cycle completes, then S_RUN.
- rst=1 mid-S_FLUSH -> next cycle flush_cmd=0, busy=0, stall_cycles=0, stall_cmd=0 while rst high. With CTRL_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cycles=4'hF.
